// File: rtl/acc_dump_mc.sv
// Multi-channel integrate-and-dump accumulator.
// A time-interleaved signed sample stream is summed per channel over a
// run-time block length. Each block's total leaves with a one-cycle strobe.
// Pipeline: p0 registers the incoming sample; p1 updates the per-channel
// state and the registered dump outputs.
module acc_dump_mc #(
  parameter int IN_WIDTH  = 47,
  parameter int OUT_WIDTH = 50,
  parameter int NCHAN     = 4,
  parameter int CHAN_W    = 2,
  parameter int CNT_W     = 16,
  parameter int SATURATE  = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        enable_in,
  input  logic [CHAN_W-1:0]           chan_in,
  input  logic signed [IN_WIDTH-1:0]  addend,
  input  logic [CNT_W-1:0]            dump_len,
  output logic                        enable_out,
  output logic [CHAN_W-1:0]           chan_out,
  output logic signed [OUT_WIDTH-1:0] sum,
  output logic                        overflow
);

  // One slot per encodable index; slots at or above NCHAN are never written.
  localparam int NSLOT = 1 << CHAN_W;
  localparam logic signed [OUT_WIDTH-1:0] SUM_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] SUM_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  // Full-width add with overflow detection; returns {overflow, result}.
  function automatic logic [OUT_WIDTH:0] sat_add(input logic signed [OUT_WIDTH-1:0] a,
                                                 input logic signed [OUT_WIDTH-1:0] b);
    logic signed [OUT_WIDTH:0]   full;
    logic signed [OUT_WIDTH-1:0] res;
    logic                        ov;
    full = $signed({a[OUT_WIDTH-1], a}) + $signed({b[OUT_WIDTH-1], b});
    ov   = full[OUT_WIDTH] ^ full[OUT_WIDTH-1];
    res  = full[OUT_WIDTH-1:0];
    if (ov && (SATURATE != 0)) res = full[OUT_WIDTH] ? SUM_MIN : SUM_MAX;
    return {ov, res};
  endfunction

  logic                        vld_p0_q, clr_p0_q;
  logic [CHAN_W-1:0]           chan_p0_q;
  logic signed [IN_WIDTH-1:0]  add_p0_q;
  logic [CNT_W-1:0]            len_p0_q;

  logic signed [OUT_WIDTH-1:0] acc_q [NSLOT];
  logic [CNT_W-1:0]            cnt_q [NSLOT];
  logic                        ovf_q [NSLOT];

  logic                        enable_out_q, overflow_q;
  logic [CHAN_W-1:0]           chan_out_q;
  logic signed [OUT_WIDTH-1:0] sum_q;

  logic signed [OUT_WIDTH-1:0] ext_p1, base_acc_p1, acc_d;
  logic [CNT_W-1:0]            base_cnt_p1, len_eff_p1, cnt_d;
  logic                        base_ovf_p1, add_ovf_p1, ovf_d, final_p1, dump_d;
  logic                        chan_ok;

  assign chan_ok = (32'(chan_in) < 32'(NCHAN));

  // ---- stage p0: capture sample; control bits take the async reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p0_q <= 1'b0;
      clr_p0_q <= 1'b0;
    end else begin
      vld_p0_q <= enable_in && chan_ok;
      clr_p0_q <= clear;
    end
  end

  // Sample payload is only consumed when vld_p0_q is set, so it needs no reset.
  always_ff @(posedge clock) begin
    chan_p0_q <= chan_in;
    add_p0_q  <= addend;
    len_p0_q  <= dump_len;
  end

  // ---- stage p1: next-state for the addressed channel (clear acts as a zero base)
  always_comb begin
    ext_p1      = OUT_WIDTH'(add_p0_q);
    base_acc_p1 = clr_p0_q ? '0   : acc_q[chan_p0_q];
    base_cnt_p1 = clr_p0_q ? '0   : cnt_q[chan_p0_q];
    base_ovf_p1 = clr_p0_q ? 1'b0 : ovf_q[chan_p0_q];
    {add_ovf_p1, acc_d} = sat_add(base_acc_p1, ext_p1);
    len_eff_p1  = (len_p0_q == '0) ? CNT_W'(1) : len_p0_q;
    final_p1    = (base_cnt_p1 >= (len_eff_p1 - CNT_W'(1)));
    cnt_d       = base_cnt_p1 + CNT_W'(1);
    ovf_d       = base_ovf_p1 | add_ovf_p1;
    dump_d      = vld_p0_q && final_p1;
  end

  // Per-channel state update and registered dump outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NSLOT; c++) begin
        acc_q[c] <= '0;
        cnt_q[c] <= '0;
        ovf_q[c] <= 1'b0;
      end
      enable_out_q <= 1'b0;
      sum_q        <= '0;
      chan_out_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      enable_out_q <= dump_d;
      if (clr_p0_q) begin
        for (int c = 0; c < NSLOT; c++) begin
          acc_q[c] <= '0;
          cnt_q[c] <= '0;
          ovf_q[c] <= 1'b0;
        end
      end
      if (vld_p0_q) begin
        if (final_p1) begin
          sum_q             <= acc_d;
          chan_out_q        <= chan_p0_q;
          overflow_q        <= ovf_d;
          acc_q[chan_p0_q]  <= '0;
          cnt_q[chan_p0_q]  <= '0;
          ovf_q[chan_p0_q]  <= 1'b0;
        end else begin
          acc_q[chan_p0_q]  <= acc_d;
          cnt_q[chan_p0_q]  <= cnt_d;
          ovf_q[chan_p0_q]  <= ovf_d;
        end
      end
    end
  end

  assign enable_out = enable_out_q;
  assign sum        = sum_q;
  assign chan_out   = chan_out_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_acc_dump_mc.sv
// Bench for acc_dump_mc: a default-parameter instance checked cycle by cycle
// against an integer reference model, plus a small 8-bit wrapping
// single-channel instance checked with directed blocks.
module tb_acc_dump_mc;

  localparam int  NCH  = 4;
  localparam longint MAXV = (longint'(1) <<< 49) - 1;
  localparam longint MINV = -(longint'(1) <<< 49);

  logic clock = 1'b0;
  logic reset;

  // main instance
  logic               clear, enable_in, enable_out, overflow;
  logic [1:0]         chan_in, chan_out;
  logic signed [46:0] addend;
  logic [15:0]        dump_len;
  logic signed [49:0] sum;

  // 8-bit wrapping single-channel instance
  logic               w_clear, w_enable_in, w_enable_out, w_overflow;
  logic [0:0]         w_chan_in, w_chan_out;
  logic signed [7:0]  w_addend, w_sum;
  logic [15:0]        w_dump_len;

  acc_dump_mc u_dut (
    .clock(clock), .reset(reset), .clear(clear), .enable_in(enable_in),
    .chan_in(chan_in), .addend(addend), .dump_len(dump_len),
    .enable_out(enable_out), .chan_out(chan_out), .sum(sum), .overflow(overflow)
  );

  acc_dump_mc #(.IN_WIDTH(8), .OUT_WIDTH(8), .NCHAN(1), .CHAN_W(1), .CNT_W(16), .SATURATE(0)) u_wrap (
    .clock(clock), .reset(reset), .clear(w_clear), .enable_in(w_enable_in),
    .chan_in(w_chan_in), .addend(w_addend), .dump_len(w_dump_len),
    .enable_out(w_enable_out), .chan_out(w_chan_out), .sum(w_sum), .overflow(w_overflow)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model (main instance) ----------------
  typedef struct { bit vld; int ch; longint s; bit o; } dump_t;

  longint macc [NCH];
  int     mcnt [NCH];
  bit     movf [NCH];
  dump_t  e0, e1, hold;
  int     cur_len;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      macc[c] = 0; mcnt[c] = 0; movf[c] = 0;
    end
    e0   = '{vld:1'b0, ch:0, s:0, o:1'b0};
    e1   = e0;
    hold = e0;
  endtask

  task automatic model(input bit clr, input bit en, input int ch, input longint a,
                       input int len, output dump_t r);
    longint nv;
    int     l;
    bit     o;
    r = '{vld:1'b0, ch:0, s:0, o:1'b0};
    if (clr)
      for (int c = 0; c < NCH; c++) begin
        macc[c] = 0; mcnt[c] = 0; movf[c] = 0;
      end
    if (en && ch < NCH) begin
      l  = (len == 0) ? 1 : len;
      nv = macc[ch] + a;
      o  = (nv > MAXV) || (nv < MINV);
      if (nv > MAXV) nv = MAXV;
      if (nv < MINV) nv = MINV;
      if (mcnt[ch] + 1 >= l) begin
        r = '{vld:1'b1, ch:ch, s:nv, o:(movf[ch] | o)};
        macc[ch] = 0; mcnt[ch] = 0; movf[ch] = 0;
      end else begin
        macc[ch] = nv; mcnt[ch] = mcnt[ch] + 1; movf[ch] = movf[ch] | o;
      end
    end
  endtask

  // One clock of the main instance: check outputs for the sample driven two
  // cycles earlier, then drive the next sample and advance the model.
  task automatic step(input bit clr, input bit en, input int ch, input longint a, input int len);
    dump_t r;
    @(negedge clock);
    if (e0.vld) hold = e0;
    chk("enable_out", enable_out, e0.vld);
    chk("sum",        sum,        hold.s);
    chk("chan_out",   chan_out,   hold.ch);
    chk("overflow",   overflow,   hold.o);
    clear     = clr;
    enable_in = en;
    chan_in   = ch[1:0];
    addend    = a[46:0];
    dump_len  = len[15:0];
    cur_len   = len;
    model(clr, en, ch, a, len, r);
    e0 = e1;
    e1 = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, cur_len);
  endtask

  // ---------------- directed blocks (wrapping instance) ----------------
  logic signed [7:0] w_val [8];
  logic [0:0]        w_ch  [8];

  task automatic w_block(input int n, input int len, input longint exp_s, input bit exp_o);
    w_dump_len = 16'(len);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      chk("w_early_strobe", w_enable_out, 0);
      w_enable_in = 1'b1;
      w_chan_in   = w_ch[i];
      w_addend    = w_val[i];
    end
    @(negedge clock);
    chk("w_early_strobe", w_enable_out, 0);
    w_enable_in = 1'b0;
    @(negedge clock);
    chk("w_strobe",   w_enable_out, 1);
    chk("w_sum",      w_sum,        exp_s);
    chk("w_chan_out", w_chan_out,   0);
    chk("w_overflow", w_overflow,   exp_o);
  endtask

  logic signed [46:0] r47;
  longint a;
  int     ln;

  initial begin
    reset = 1'b1;
    clear = 1'b0; enable_in = 1'b0; chan_in = '0; addend = '0; dump_len = 16'd1;
    w_clear = 1'b0; w_enable_in = 1'b0; w_chan_in = '0; w_addend = '0; w_dump_len = 16'd1;
    cur_len = 1;
    model_reset();
    repeat (3) @(negedge clock);
    chk("rst enable_out", enable_out, 0);
    chk("rst sum",        sum,        0);
    chk("rst chan_out",   chan_out,   0);
    chk("rst overflow",   overflow,   0);
    chk("rst w_sum",      w_sum,      0);
    reset = 1'b0;

    // wrap instance: 100,100,-50 -> 150 wraps to -106 with overflow
    w_val[0] = 8'sd100; w_val[1] = 8'sd100; w_val[2] = -8'sd50;
    w_ch[0] = 1'b0; w_ch[1] = 1'b0; w_ch[2] = 1'b0;
    w_block(3, 3, -106, 1'b1);
    // single channel 1,2,3,4 with an out-of-range channel sample dropped
    w_val[0] = 8'sd1; w_val[1] = 8'sd2; w_val[2] = 8'sd99; w_val[3] = 8'sd3; w_val[4] = 8'sd4;
    w_ch[0] = 1'b0; w_ch[1] = 1'b0; w_ch[2] = 1'b1; w_ch[3] = 1'b0; w_ch[4] = 1'b0;
    w_block(5, 4, 10, 1'b0);
    // 100+100 wraps to -56
    w_val[0] = 8'sd100; w_val[1] = 8'sd100; w_ch[0] = 1'b0; w_ch[1] = 1'b0;
    w_block(2, 2, -56, 1'b1);

    // round robin, dump_len 2, addend 10*chan+k
    step(1'b1, 1'b0, 0, 0, 2);
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < NCH; c++) step(1'b0, 1'b1, c, 10 * c + k, 2);
    idle(2);
    chk("rr last sum", sum, 61);

    // -1 x5, dump_len 5 -> -5 through the sign extension
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 0, -1, 5);
    idle(2);
    chk("neg sum", sum, -5);

    // saturation high and low, dump_len 9
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1, (longint'(1) <<< 46) - 1, 9);
    idle(2);
    chk("sat hi sum", sum, MAXV);
    chk("sat hi ovf", overflow, 1);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 2, -(longint'(1) <<< 46), 9);
    idle(2);
    chk("sat lo sum", sum, MINV);

    // clear with a sample mid-block: 5,5 | clear+7 | 1,1 -> 9
    step(1'b0, 1'b1, 0, 5, 3);
    step(1'b0, 1'b1, 0, 5, 3);
    step(1'b1, 1'b1, 0, 7, 3);
    step(1'b0, 1'b1, 0, 1, 3);
    step(1'b0, 1'b1, 0, 1, 3);
    idle(2);
    chk("clear sum", sum, 9);
    chk("clear ovf", overflow, 0);

    // lowering dump_len below an in-progress count dumps on the next sample
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3, 2, 5);
    step(1'b0, 1'b1, 3, 4, 2);
    idle(2);
    chk("live len sum", sum, 10);

    // randomized traffic
    ln = 3;
    for (int i = 0; i < 1500; i++) begin
      r47 = 47'({$urandom(), $urandom()});
      a   = (($urandom_range(0, 3) == 0) ? longint'(r47) : longint'($urandom_range(0, 200)) - 100);
      if ($urandom_range(0, 39) == 0) begin
        ln = $urandom_range(0, 12);
        step(1'b1, ($urandom_range(0, 1) == 1), $urandom_range(0, 3), a, ln);
      end else begin
        step(1'b0, ($urandom_range(0, 3) != 0), $urandom_range(0, 3), a, ln);
      end
    end
    idle(2);

    // async reset mid-block: outputs return to 0 and the partial block is lost
    step(1'b0, 1'b1, 2, 5, 4);
    step(1'b0, 1'b1, 2, 6, 4);
    chk("pre-rst sum nonzero", (sum != 0), 1);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("mid rst enable_out", enable_out, 0);
    chk("mid rst sum",        sum,        0);
    chk("mid rst chan_out",   chan_out,   0);
    chk("mid rst overflow",   overflow,   0);
    @(negedge clock);
    enable_in = 1'b0;
    clear     = 1'b0;
    @(negedge clock);
    chk("held rst sum", sum, 0);
    reset = 1'b0;
    model_reset();
    step(1'b0, 1'b1, 2, 1, 2);
    step(1'b0, 1'b1, 2, 1, 2);
    idle(2);
    chk("post rst ch2 sum", sum, 2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 0, -3, 0);
    idle(2);
    chk("len0 sum", sum, -3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
